// File: rtl/mult_pkg.sv
// Elaboration-time sizing helpers for the pipelined Wallace multiplier:
// tree row counts, layer counts and how the layers are spread over the stages.
package mult_pkg;

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    // WIDTH partial-product rows plus one Baugh-Wooley correction row.
    function automatic int pp_rows(input int width);
        return width + 1;
    endfunction

    // Rows still to be compressed in front of the given layer index.
    function automatic int rows_at_layer(input int width, input int layer);
        int rows;
        rows = pp_rows(width);
        for (int l = 0; l < layer; l++) begin
            if (rows > 2) begin
                rows = 2 * (rows / 3) + (rows % 3);
            end
        end
        return rows;
    endfunction

    // Number of 3:2 layers needed to bring the tree down to two rows.
    function automatic int csa_layers(input int width);
        int rows;
        int n;
        rows = pp_rows(width);
        n = 0;
        while (rows > 2) begin
            rows = 2 * (rows / 3) + (rows % 3);
            n++;
        end
        return n;
    endfunction

    // Layers placed in front of register s; the final register only gets the CPA,
    // except with a single stage where everything sits in front of it.
    function automatic int stage_layers(input int width, input int stages, input int s);
        int total;
        int groups;
        total = csa_layers(width);
        if (stages == 1) begin
            return total;
        end
        if (s >= stages - 1) begin
            return 0;
        end
        groups = stages - 1;
        return (total / groups) + ((s < (total % groups)) ? 1 : 0);
    endfunction

    function automatic int layers_before(input int width, input int stages, input int s);
        int n;
        n = 0;
        for (int k = 0; k < s; k++) begin
            n += stage_layers(width, stages, k);
        end
        return n;
    endfunction

endpackage

// File: rtl/csa_row.sv
// Bitwise 3:2 carry-save compressor over N bits; the carry row is pre-shifted
// into its weight so the caller can treat sum and carry as ordinary addends.
module csa_row #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    assign sum   = x ^ y ^ z;
    assign carry = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/pipelined_wallace_mult.sv
// Pipelined Wallace-tree multiplier: Baugh-Wooley partial products, CSA layers spread
// over the first STAGES-1 registers, carry-propagate add in front of the last register.
module pipelined_wallace_mult
    import mult_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PROD_W = prod_w(WIDTH);
    localparam int ROWS   = pp_rows(WIDTH);
    // Modified Baugh-Wooley correction: +2^WIDTH + 2^(2*WIDTH-1), modulo 2^PROD_W.
    localparam logic [PROD_W-1:0] BW_CONST =
        (PROD_W'(1) << WIDTH) | (PROD_W'(1) << (PROD_W - 1));

    // Handshake: a transfer happens at a rising edge where valid && ready. Stage k
    // may load whenever it is empty or its successor loads too (ready_k = !valid_k ||
    // ready_{k+1}, ready_STAGES = out_ready), so bubbles collapse and order is kept.
    logic [STAGES-1:0]  valid_q;
    logic [STAGES:0]    rdy;
    logic [TAG_W-1:0]   tag_q     [STAGES];
    logic [PROD_W-1:0]  rows_q    [STAGES][ROWS];
    logic [PROD_W-1:0]  stage_out [STAGES][ROWS];
    logic [WIDTH-1:0]   pp_bits   [WIDTH];
    logic [PROD_W-1:0]  pp_row    [ROWS];

    always_comb begin
        rdy = '0;
        rdy[STAGES] = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            rdy[s] = !valid_q[s] || rdy[s+1];
        end
    end

    assign in_ready  = rdy[0] && !rst;
    assign out_valid = valid_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign product   = rows_q[STAGES-1][0];

    // Signed mode inverts the bits where exactly one operand index is the sign bit.
    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            for (int i = 0; i < WIDTH; i++) begin
                pp_bits[j][i] = (a[i] & b[j]) ^
                                (is_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_pp
        assign pp_row[j] = {{WIDTH{1'b0}}, pp_bits[j]} << j;
    end
    assign pp_row[WIDTH] = is_signed ? BW_CONST : '0;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FIRST = layers_before(WIDTH, STAGES, s);
        localparam int NL    = stage_layers(WIDTH, STAGES, s);

        logic [PROD_W-1:0] lr [NL+1][ROWS];

        for (genvar r = 0; r < ROWS; r++) begin : g_in
            if (s == 0) begin : g_from_pp
                assign lr[0][r] = pp_row[r];
            end else begin : g_from_reg
                assign lr[0][r] = rows_q[s-1][r];
            end
        end

        for (genvar l = 0; l < NL; l++) begin : g_layer
            localparam int CNT = rows_at_layer(WIDTH, FIRST + l);
            localparam int GRP = CNT / 3;

            for (genvar g = 0; g < GRP; g++) begin : g_csa
                csa_row #(.N(PROD_W)) u_csa (
                    .x     (lr[l][3*g]),
                    .y     (lr[l][3*g+1]),
                    .z     (lr[l][3*g+2]),
                    .sum   (lr[l+1][2*g]),
                    .carry (lr[l+1][2*g+1])
                );
            end

            // Rows left over from the triplets pass straight down; the tail is zero.
            for (genvar r = 2 * GRP; r < ROWS; r++) begin : g_pass
                if (r < CNT - GRP) begin : g_keep
                    assign lr[l+1][r] = lr[l][r+GRP];
                end else begin : g_zero
                    assign lr[l+1][r] = '0;
                end
            end
        end

        for (genvar r = 0; r < ROWS; r++) begin : g_out
            if (s == STAGES - 1) begin : g_last
                if (r == 0) begin : g_cpa
                    assign stage_out[s][r] = lr[NL][0] + lr[NL][1];
                end else begin : g_zero
                    assign stage_out[s][r] = '0;
                end
            end else begin : g_mid
                assign stage_out[s][r] = lr[NL][r];
            end
        end
    end

    // Data registers load on ready regardless of valid; only valid_q needs to be exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                tag_q[s] <= '0;
                for (int r = 0; r < ROWS; r++) begin
                    rows_q[s][r] <= '0;
                end
            end
        end else begin
            if (rdy[0]) begin
                valid_q[0] <= in_valid;
                tag_q[0]   <= in_tag;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (rdy[s]) begin
                    valid_q[s] <= valid_q[s-1];
                    tag_q[s]   <= tag_q[s-1];
                end
            end
            for (int s = 0; s < STAGES; s++) begin
                if (rdy[s]) begin
                    for (int r = 0; r < ROWS; r++) begin
                        rows_q[s][r] <= stage_out[s][r];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_wallace_mult.sv
// Randomised and directed bench for pipelined_wallace_mult with a queue scoreboard
// checked by an independent output monitor.
module tb_pipelined_wallace_mult;

    localparam int W      = 16;
    localparam int STAGES = 3;
    localparam int TW     = 4;
    localparam int PW     = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          is_signed = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] product;
    logic [TW-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    int run_len  = 0;
    int max_run  = 0;

    logic [TW+PW-1:0] exp_q[$];
    int               lat_q[$];
    logic [TW-1:0]    tag_n = '0;

    pipelined_wallace_mult #(.WIDTH(W), .STAGES(STAGES), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
        logic [PW-1:0] xe;
        logic [PW-1:0] ye;
        xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ye = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: drive after the edge, decide acceptance on the falling edge.
    task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic is, input logic [TW-1:0] it, input logic ordy,
                         input bit lat, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        is_signed = is;
        in_tag    = it;
        out_ready = ordy;
        @(negedge clk);
        acc = iv && in_ready && !rst;
        if (acc) begin
            exp_q.push_back({it, ref_mul(ia, ib, is)});
            lat_q.push_back(lat ? cyc : -1);
        end
    endtask

    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                        input bit lat);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            cycle(1'b1, ia, ib, is, tag_n, 1'b1, lat, acc);
            tries++;
        end
        check("send_accepted", acc, 1'b1);
        if (acc) tag_n++;
    endtask

    task automatic drain();
        bit acc;
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic             hold_pend = 1'b0;
    logic [PW-1:0]    last_prod;
    logic [TW-1:0]    last_tag;
    logic [TW+PW-1:0] mon_ent;
    int               mon_lat;

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid_known", $isunknown(out_valid), 1'b0);
            if (hold_pend) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_product", product, last_prod);
                check("hold_tag", out_tag, last_tag);
            end
            if (out_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual tag %0h product %0h, required no output",
                             out_tag, product);
                end else begin
                    mon_ent = exp_q.pop_front();
                    mon_lat = lat_q.pop_front();
                    check("product", product, mon_ent[PW-1:0]);
                    check("tag", out_tag, mon_ent[TW+PW-1:PW]);
                    if (mon_lat >= 0) check("latency", cyc - mon_lat, STAGES);
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            hold_pend = out_valid && !out_ready && !rst;
            last_prod = product;
            last_tag  = out_tag;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit            acc;
        int            sent;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic          rs;
        logic [W-1:0]  msb;
        logic          iv;
        logic          ordy;

        msb = '0;
        msb[W-1] = 1'b1;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_product", product, '0);
        check("reset_out_tag", out_tag, '0);
        check("reset_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1'b1);

        // basic, mixed signedness back-to-back, corners
        send(W'(3), W'(5), 1'b0, 1'b1);
        send('1, W'(2), 1'b1, 1'b1);
        send('1, W'(2), 1'b0, 1'b1);
        send('1, '1, 1'b0, 1'b1);
        send(msb, msb, 1'b1, 1'b1);
        send(msb, ~msb, 1'b1, 1'b1);
        send('0, W'($urandom()), 1'b1, 1'b1);
        send('0, W'($urandom()), 1'b0, 1'b1);
        send('1, '1, 1'b1, 1'b1);
        drain();

        // backpressure: six ops, consumer stalled for eight cycles
        tag_n = '0;
        sent = 0;
        ra = W'($urandom()); rb = W'($urandom()); rs = 1'(($urandom()));
        for (int k = 0; k < 8; k++) begin
            cycle(sent < 6, ra, rb, rs, tag_n, 1'b0, 1'b0, acc);
            if (acc) begin
                sent++; tag_n++;
                ra = W'($urandom()); rb = W'($urandom()); rs = 1'(($urandom()));
            end
        end
        check("bp_accepts", sent, (STAGES < 6) ? STAGES : 6);
        check("bp_in_ready_low", in_ready, 1'b0);
        for (int k = 0; k < 64 && sent < 6; k++) begin
            cycle(1'b1, ra, rb, rs, tag_n, 1'b1, 1'b0, acc);
            if (acc) begin
                sent++; tag_n++;
                ra = W'($urandom()); rb = W'($urandom()); rs = 1'(($urandom()));
            end
        end
        check("bp_all_sent", sent, 6);
        drain();

        // reset with operations in flight
        sent = 0;
        for (int k = 0; k < 16 && sent < 2; k++) begin
            cycle(1'b1, W'($urandom()), W'($urandom()), 1'b1, tag_n, 1'b0, 1'b0, acc);
            if (acc) begin sent++; tag_n++; end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_during_reset", in_ready, 1'b0);
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("out_valid_after_midreset", out_valid, 1'b0);
        send(W'(7), W'(9), 1'b0, 1'b1);
        drain();

        // random traffic with random stalls on both sides
        sent = 0;
        ra = W'($urandom()); rb = W'($urandom()); rs = 1'(($urandom()));
        for (int k = 0; k < 20000 && sent < 2000; k++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            cycle(iv, ra, rb, rs, tag_n, ordy, 1'b0, acc);
            if (acc) begin
                sent++; tag_n++;
                ra = W'($urandom()); rb = W'($urandom()); rs = 1'(($urandom()));
            end
        end
        check("random_ops_sent", sent, 2000);
        drain();

        // full-throughput window
        max_run = 0;
        sent = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, W'($urandom()), W'($urandom()), 1'(($urandom())), tag_n, 1'b1, 1'b1, acc);
            if (acc) begin sent++; tag_n++; end
        end
        check("tput_accepts", sent, 8);
        drain();
        check("tput_handoff_run", max_run >= 8, 1'b1);

        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
